system_sync: RTL and testbench
==============================

# system_sync

Parametrised successor to the single-channel system command block. Services the host command stream (version, multi-word time read, time synchronisation, capture readout) and timestamps up to NCH asynchronous sync-pulse inputs against the local time base. Sits between the command decoder and the system time counter. Drives `time_out`/`time_out_en` to re-base the counter.

## Interface
- CMD_BITS, 8, command code width
- CMD_GET_VERSION / RSP_GET_VERSION, 0 / 0, version command and response codes
- CMD_SYNC_TIME, 1, time-sync command code (no response)
- CMD_GET_TIME / RSP_GET_TIME, 2 / 1, time read command and response codes
- CMD_GET_CAPTURE / RSP_GET_CAPTURE, 3 / 2, capture readout command and response codes
- VERSION, 2, value returned by GET_VERSION
- TIME_BITS, 64, time width; multiple of 32; NWORDS = TIME_BITS/32
- NCH, 4, number of sync channels, 1..16
- SYNC_LATENCY, 4, constant added in SYNC_TIME (2 sync flops + capture + apply)

Ports:
- clk  in  1  system clock
- rst_n  in  1  **one clock; reset is synchronous and active-low**
- cmd  in  CMD_BITS  command code, valid with cmd_ready
- cmd_ready  in  1  command pending; sampled only in IDLE
- arg_data  in  32  current argument word
- arg_advance  out  1  one-cycle pulse: current arg word consumed, next word visible next cycle
- cmd_done  out  1  one-cycle pulse: command finished
- param_data  out  32  response word / response code
- param_write  out  1  high while param_data carries response words
- time_in  in  TIME_BITS  current system time
- time_out  out  TIME_BITS  new system time
- time_out_en  out  1  one-cycle load strobe for time_out
- pulse_in  in  NCH  async sync pulses; every transition is an event
- latch_in  in  NCH  async latch requests; rising edge locks the channel

## Operation
- Reset (rst_n low at clk edge): all outputs 0, state IDLE, every capture register, lock bit, miss bit and synchroniser flop 0. A command in progress is abandoned; no cmd_done.
- Per channel: 2-flop synchroniser on pulse_in and latch_in, then edge detect against a previous-value flop.
  - Pulse edge, unlocked: cap[c] <= time_in.
  - Pulse edge, locked: miss[c] <= 1; cap unchanged.
  - Latch rising edge: locked[c] <= 1.
  - Both in the same cycle: capture and lock both take effect.
- States: IDLE, ARGS, APPLY, STREAM, END.
- IDLE + cmd_ready, decode cmd:
  - GET_VERSION -> STREAM with one word: VERSION.
  - GET_TIME -> snapshot time_in, then STREAM NWORDS words, least significant first.
  - GET_CAPTURE -> ARGS, consuming 1 word (channel). Then snapshot and STREAM 1+NWORDS words: status {30'b0, miss, locked} first, then cap least significant first.
  - SYNC_TIME -> ARGS, consuming 1+NWORDS words: channel, then offset least significant first. Then APPLY.
  - Unknown code -> END with no response words.
- ARGS: arg_advance pulses once per consumed word; one word per cycle.
- APPLY: time_out <= time_in - cap[ch] + offset + SYNC_LATENCY, arithmetic modulo 2^TIME_BITS. time_out_en=1 and cmd_done=1 for one cycle. Clears locked[ch] and miss[ch]. Returns to IDLE.
- STREAM: param_write=1, one word per cycle, then END.
- END: param_write=0 and cmd_done=1 for one cycle; param_data=response code (none for unknown codes). Returns to IDLE.
- Channel index >= NCH:
  - GET_CAPTURE returns status 0xFFFFFFFF and zero capture words.
  - SYNC_TIME gives cmd_done without time_out_en.
- Channel capture logic runs in every state, independent of the command FSM.

## Timing
- Command accepted at edge T (state IDLE, cmd_ready=1).
- GET_VERSION: param_write=1, param_data=VERSION in cycle T+1. Cycle T+2: param_write=0, param_data=RSP_GET_VERSION, cmd_done=1.
- GET_TIME: words in cycles T+1..T+NWORDS, holding time_in as sampled at T. END in cycle T+NWORDS+1.
- SYNC_TIME: arg words consumed in cycles T+1..T+1+NWORDS. time_out_en in the following cycle.
- Pulse edge on pulse_in in cycle t: cap holds the time_in of cycle t+2, visible from t+3.
- cmd_ready is ignored outside IDLE. The decoder holds cmd until cmd_done.

## Structure
- Package system_sync_pkg: state enum, default command/response codes, NWORDS function, status-word field positions.
- Sub-module system_sync_chan: synchroniser, edge detect, cap, locked, miss, clear input. Instantiated NCH times via generate.

## Test plan
- GET_VERSION -> T+1: param_data=2, param_write=1. T+2: param_data=0, cmd_done=1 for exactly one cycle.
- time_in=0x0000_0001_FFFF_FFF0, GET_TIME -> words 0xFFFFFFF0 then 0x00000001, then RSP 1 and cmd_done.
- pulse_in[2] toggles while time_in increments by 1 from 1000 -> cap[2]=1002. latch_in[2] rises, then a second toggle -> cap unchanged, GET_CAPTURE(2) status=3.
- SYNC_TIME ch 2, offset 0x1_0000_0000, with cap=1002 and time_in=1500 -> time_out=0x1_0000_0000+498+4, time_out_en one cycle, lock and miss cleared.
- Pulse edge and latch edge in the same cycle on ch 0 -> captured and locked. GET_CAPTURE(7) with NCH=4 -> status 0xFFFFFFFF.
- rst_n low mid-STREAM -> next cycle all outputs 0, no cmd_done. A new GET_TIME then completes normally.

Source files
------------

// File: rtl/system_sync_pkg.sv
// Shared types and constants for the system_sync command block and its
// per-channel sync capture units.
package system_sync_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARGS,
        S_APPLY,
        S_STREAM,
        S_END
    } state_t;

    localparam int DEF_CMD_GET_VERSION = 0;
    localparam int DEF_RSP_GET_VERSION = 0;
    localparam int DEF_CMD_SYNC_TIME   = 1;
    localparam int DEF_CMD_GET_TIME    = 2;
    localparam int DEF_RSP_GET_TIME    = 1;
    localparam int DEF_CMD_GET_CAPTURE = 3;
    localparam int DEF_RSP_GET_CAPTURE = 2;

    localparam int STAT_LOCKED_BIT = 0;
    localparam int STAT_MISS_BIT   = 1;

    function automatic int nwords(input int time_bits);
        return time_bits / 32;
    endfunction

endpackage

// File: rtl/system_sync_chan.sv
// One sync channel: synchronises pulse/latch inputs, timestamps every pulse
// transition while unlocked, and flags pulses that arrive while locked.
module system_sync_chan
    import system_sync_pkg::*;
#(
    parameter int TIME_BITS = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pulse_in,
    input  logic                 latch_in,
    input  logic                 clear,
    input  logic [TIME_BITS-1:0] time_in,
    output logic [TIME_BITS-1:0] cap,
    output logic                 locked,
    output logic                 miss
);

    // bits [1:0] are the synchroniser, bit [2] the previous synchronised value
    logic [2:0]           p_sync_q, p_sync_d;
    logic [2:0]           l_sync_q, l_sync_d;
    logic [TIME_BITS-1:0] cap_q, cap_d;
    logic                 locked_q, locked_d;
    logic                 miss_q, miss_d;
    logic                 p_edge, l_rise;

    always_comb begin
        p_sync_d = {p_sync_q[1:0], pulse_in};
        l_sync_d = {l_sync_q[1:0], latch_in};
        p_edge   = p_sync_q[1] ^ p_sync_q[2];
        l_rise   = l_sync_q[1] & ~l_sync_q[2];
        cap_d    = cap_q;
        locked_d = locked_q | l_rise;
        miss_d   = miss_q | (p_edge & locked_q);
        if (p_edge && !locked_q) begin
            cap_d = time_in;
        end
        if (clear) begin
            locked_d = 1'b0;
            miss_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_sync_q <= '0;
            l_sync_q <= '0;
            cap_q    <= '0;
            locked_q <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            p_sync_q <= p_sync_d;
            l_sync_q <= l_sync_d;
            cap_q    <= cap_d;
            locked_q <= locked_d;
            miss_q   <= miss_d;
        end
    end

    assign cap    = cap_q;
    assign locked = locked_q;
    assign miss   = miss_q;

endmodule

// File: rtl/system_sync.sv
// Host command engine (version, time read, capture readout, time sync) in
// front of NCH sync-pulse capture channels.
module system_sync
    import system_sync_pkg::*;
#(
    parameter int CMD_BITS        = 8,
    parameter int CMD_GET_VERSION = DEF_CMD_GET_VERSION,
    parameter int RSP_GET_VERSION = DEF_RSP_GET_VERSION,
    parameter int CMD_SYNC_TIME   = DEF_CMD_SYNC_TIME,
    parameter int CMD_GET_TIME    = DEF_CMD_GET_TIME,
    parameter int RSP_GET_TIME    = DEF_RSP_GET_TIME,
    parameter int CMD_GET_CAPTURE = DEF_CMD_GET_CAPTURE,
    parameter int RSP_GET_CAPTURE = DEF_RSP_GET_CAPTURE,
    parameter int VERSION         = 2,
    parameter int TIME_BITS       = 64,
    parameter int NCH             = 4,
    parameter int SYNC_LATENCY    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CMD_BITS-1:0]  cmd,
    input  logic                 cmd_ready,
    input  logic [31:0]          arg_data,
    output logic                 arg_advance,
    output logic                 cmd_done,
    output logic [31:0]          param_data,
    output logic                 param_write,
    input  logic [TIME_BITS-1:0] time_in,
    output logic [TIME_BITS-1:0] time_out,
    output logic                 time_out_en,
    input  logic [NCH-1:0]       pulse_in,
    input  logic [NCH-1:0]       latch_in
);

    localparam int NW = nwords(TIME_BITS);
    localparam int VW = 32 * (NW + 1);

    state_t               state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [TIME_BITS-1:0] args_q, args_d;
    logic [VW-1:0]        rsp_q, rsp_d;
    logic [31:0]          rsp_code_q, rsp_code_d;
    logic                 is_sync_q, is_sync_d;
    logic [NCH-1:0]       hit_q, hit_d;
    logic [TIME_BITS-1:0] time_out_q, time_out_d;

    logic [TIME_BITS-1:0] cap [NCH];
    logic [NCH-1:0]       locked, miss, clear;
    logic [VW-1:0]        arg_next;
    logic [31:0]          ch_word, status;
    logic [NCH-1:0]       sel;
    logic [TIME_BITS-1:0] sel_cap;

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        system_sync_chan #(.TIME_BITS(TIME_BITS)) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .pulse_in(pulse_in[c]),
            .latch_in(latch_in[c]),
            .clear   (clear[c]),
            .time_in (time_in),
            .cap     (cap[c]),
            .locked  (locked[c]),
            .miss    (miss[c])
        );
    end

    // Channel word is the first argument: oldest word once all sync args are in.
    always_comb begin
        arg_next = {arg_data, args_q};
        ch_word  = is_sync_q ? arg_next[31:0] : arg_data;
        sel      = '0;
        sel_cap  = '0;
        status   = '1;
        for (int c = 0; c < NCH; c++) begin
            if (ch_word == 32'(c)) begin
                sel[c]                  = 1'b1;
                sel_cap                 = cap[c];
                status                  = '0;
                status[STAT_LOCKED_BIT] = locked[c];
                status[STAT_MISS_BIT]   = miss[c];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        args_d      = args_q;
        rsp_d       = rsp_q;
        rsp_code_d  = rsp_code_q;
        is_sync_d   = is_sync_q;
        hit_d       = hit_q;
        time_out_d  = time_out_q;
        arg_advance = 1'b0;
        cmd_done    = 1'b0;
        param_data  = '0;
        param_write = 1'b0;
        time_out_en = 1'b0;
        clear       = '0;
        case (state_q)
            S_IDLE: begin
                if (cmd_ready) begin
                    if (cmd == CMD_BITS'(CMD_GET_VERSION)) begin
                        rsp_d      = VW'(VERSION);
                        rsp_code_d = 32'(RSP_GET_VERSION);
                        cnt_d      = 16'd1;
                        state_d    = S_STREAM;
                    end else if (cmd == CMD_BITS'(CMD_GET_TIME)) begin
                        rsp_d      = VW'(time_in);
                        rsp_code_d = 32'(RSP_GET_TIME);
                        cnt_d      = 16'(NW);
                        state_d    = S_STREAM;
                    end else if (cmd == CMD_BITS'(CMD_GET_CAPTURE)) begin
                        rsp_code_d = 32'(RSP_GET_CAPTURE);
                        is_sync_d  = 1'b0;
                        cnt_d      = 16'd1;
                        state_d    = S_ARGS;
                    end else if (cmd == CMD_BITS'(CMD_SYNC_TIME)) begin
                        rsp_code_d = '0;
                        is_sync_d  = 1'b1;
                        cnt_d      = 16'(NW + 1);
                        state_d    = S_ARGS;
                    end else begin
                        rsp_code_d = '0;
                        state_d    = S_END;
                    end
                end
            end
            S_ARGS: begin
                arg_advance = 1'b1;
                args_d      = arg_next[VW-1:32];
                cnt_d       = cnt_q - 16'd1;
                if (cnt_q == 16'd1) begin
                    if (is_sync_q) begin
                        hit_d = sel;
                        if (|sel) begin
                            time_out_d = time_in - sel_cap + arg_next[VW-1:32]
                                       + TIME_BITS'(SYNC_LATENCY);
                        end
                        state_d = S_APPLY;
                    end else begin
                        rsp_d   = {sel_cap, status};
                        cnt_d   = 16'(NW + 1);
                        state_d = S_STREAM;
                    end
                end
            end
            S_APPLY: begin
                time_out_en = |hit_q;
                cmd_done    = 1'b1;
                clear       = hit_q;
                state_d     = S_IDLE;
            end
            S_STREAM: begin
                param_write = 1'b1;
                param_data  = rsp_q[31:0];
                rsp_d       = rsp_q >> 32;
                cnt_d       = cnt_q - 16'd1;
                if (cnt_q == 16'd1) begin
                    state_d = S_END;
                end
            end
            S_END: begin
                cmd_done   = 1'b1;
                param_data = rsp_code_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            args_q     <= '0;
            rsp_q      <= '0;
            rsp_code_q <= '0;
            is_sync_q  <= 1'b0;
            hit_q      <= '0;
            time_out_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            args_q     <= args_d;
            rsp_q      <= rsp_d;
            rsp_code_q <= rsp_code_d;
            is_sync_q  <= is_sync_d;
            hit_q      <= hit_d;
            time_out_q <= time_out_d;
        end
    end

    assign time_out = time_out_q;

endmodule

// File: tb/tb_system_sync.sv
// Randomised self-checking bench for system_sync against a cycle-level
// behavioural model of the capture channels and command responses.
module tb_system_sync;

    localparam int NCH = 4;
    localparam int NW  = 2;
    localparam logic [7:0] C_VER  = 8'd0;
    localparam logic [7:0] C_SYNC = 8'd1;
    localparam logic [7:0] C_TIME = 8'd2;
    localparam logic [7:0] C_CAP  = 8'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cmd;
    logic        cmd_ready;
    logic [31:0] arg_data;
    logic        arg_advance, cmd_done, param_write, time_out_en;
    logic [31:0] param_data;
    logic [63:0] time_in, time_out;
    logic [NCH-1:0] pulse_in, latch_in;

    always #5 clk = ~clk;

    system_sync #(.NCH(NCH)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_ready(cmd_ready),
        .arg_data(arg_data), .arg_advance(arg_advance), .cmd_done(cmd_done),
        .param_data(param_data), .param_write(param_write),
        .time_in(time_in), .time_out(time_out), .time_out_en(time_out_en),
        .pulse_in(pulse_in), .latch_in(latch_in)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic time_run;

    // Model: an input transition becomes effective three edges after it is first sampled.
    logic [63:0] m_cap  [NCH];
    logic        m_lock [NCH];
    logic        m_miss [NCH];
    logic [2:0]  ph [NCH];
    logic [2:0]  lh [NCH];

    logic [31:0] r_words[$];
    int          r_first, r_done_cyc, r_done_cnt, r_adv_cnt, r_en_cnt, r_en_cyc;
    logic [31:0] r_end_data;
    logic        r_done_pw, r_extra_done, r_extra_en;
    logic [63:0] r_tout, r_t_acc;

    task automatic tick_clr(input logic [NCH-1:0] clr);
        for (int c = 0; c < NCH; c++) begin
            if (!rst_n) begin
                m_cap[c] = '0; m_lock[c] = 1'b0; m_miss[c] = 1'b0;
                ph[c] = '0; lh[c] = '0;
            end else begin
                if (ph[c][1] != ph[c][2]) begin
                    if (m_lock[c]) m_miss[c] = 1'b1;
                    else           m_cap[c]  = time_in;
                end
                if (lh[c][1] && !lh[c][2]) m_lock[c] = 1'b1;
                if (clr[c]) begin m_lock[c] = 1'b0; m_miss[c] = 1'b0; end
                ph[c] = {ph[c][1:0], pulse_in[c]};
                lh[c] = {lh[c][1:0], latch_in[c]};
            end
        end
        @(posedge clk); #1;
        if (time_run) time_in = time_in + 64'd1;
    endtask

    task automatic tick();
        tick_clr('0);
    endtask

    function automatic logic [95:0] packw();
        logic [95:0] v = '0;
        for (int i = 0; i < r_words.size() && i < 3; i++) v[i*32 +: 32] = r_words[i];
        return v;
    endfunction

    task automatic run_cmd(input logic [7:0] code, input logic [31:0] a0, a1, a2);
        logic [31:0] args [3];
        int ai;
        logic adv, fin;
        logic [NCH-1:0] clr;
        args[0] = a0; args[1] = a1; args[2] = a2;
        r_words.delete();
        r_first = -1; r_done_cyc = -1; r_done_cnt = 0; r_adv_cnt = 0;
        r_en_cnt = 0; r_en_cyc = -1; r_end_data = '0; r_done_pw = 1'b0; r_tout = '0;
        cmd = code; cmd_ready = 1'b1; arg_data = args[0]; ai = 0; r_t_acc = time_in;
        tick();
        cmd_ready = 1'b0;
        fin = 1'b0;
        for (int cyc = 1; cyc <= 30 && !fin; cyc++) begin
            adv = arg_advance;
            if (adv) r_adv_cnt++;
            if (param_write) begin
                r_words.push_back(param_data);
                if (r_first < 0) r_first = cyc;
            end
            if (time_out_en) begin r_en_cnt++; r_en_cyc = cyc; r_tout = time_out; end
            if (cmd_done) begin
                r_done_cnt++; r_done_cyc = cyc; r_end_data = param_data;
                r_done_pw = param_write; fin = 1'b1;
            end
            clr = '0;
            if (code == C_SYNC && cyc == 2 + NW && a0 < NCH) clr[int'(a0)] = 1'b1;
            tick_clr(clr);
            if (adv && ai < 2) begin ai++; arg_data = args[ai]; end
        end
        r_extra_done = cmd_done;
        r_extra_en   = time_out_en;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({arg_advance, cmd_done, param_write, time_out_en} !== 4'b0)
            $display("FAIL reset_strobes: got %b expected 0000", {arg_advance, cmd_done, param_write, time_out_en});
        else n_pass++;
        n_checks++;
        if (param_data !== 32'd0) $display("FAIL reset_param_data: got %h expected 0", param_data);
        else n_pass++;
        n_checks++;
        if (time_out !== 64'd0) $display("FAIL reset_time_out: got %h expected 0", time_out);
        else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_version();
        run_cmd(C_VER, 0, 0, 0);
        n_checks++;
        if (r_words.size() != 1 || packw() !== 96'd2)
            $display("FAIL version_word: got n=%0d %h expected n=1 2", r_words.size(), packw());
        else n_pass++;
        n_checks++;
        if (r_first != 1 || r_done_cyc != 2)
            $display("FAIL version_timing: got word@%0d done@%0d expected 1 and 2", r_first, r_done_cyc);
        else n_pass++;
        n_checks++;
        if (r_end_data !== 32'd0 || r_done_pw !== 1'b0 || r_extra_done !== 1'b0)
            $display("FAIL version_end: got code %h pw %b done_after %b expected 0 0 0", r_end_data, r_done_pw, r_extra_done);
        else n_pass++;
    endtask

    task automatic test_get_time();
        logic [63:0] t;
        time_run = 1'b0;
        time_in  = 64'h0000_0001_FFFF_FFF0;
        run_cmd(C_TIME, 0, 0, 0);
        n_checks++;
        if (r_words.size() != 2 || packw() !== 96'h0000_0001_FFFF_FFF0)
            $display("FAIL time_words: got n=%0d %h expected n=2 00000001fffffff0", r_words.size(), packw());
        else n_pass++;
        n_checks++;
        if (r_done_cyc != 3 || r_end_data !== 32'd1 || r_extra_done !== 1'b0)
            $display("FAIL time_end: got done@%0d code %h after %b expected 3 1 0", r_done_cyc, r_end_data, r_extra_done);
        else n_pass++;
        time_run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            time_in = {$urandom, $urandom};
            t = time_in;
            run_cmd(C_TIME, 0, 0, 0);
            n_checks++;
            if (r_words.size() != 2 || packw() !== {32'd0, t} || r_done_cyc != 3)
                $display("FAIL time_rand%0d: got n=%0d %h done@%0d expected %h done@3", i, r_words.size(), packw(), r_done_cyc, t);
            else n_pass++;
        end
    endtask

    task automatic test_capture();
        time_run = 1'b1;
        repeat (4) tick();
        time_in = 64'd1000;
        pulse_in[2] = ~pulse_in[2];
        repeat (6) tick();
        run_cmd(C_CAP, 2, 0, 0);
        n_checks++;
        if (r_words.size() != 3 || packw() !== {64'd1002, 32'd0})
            $display("FAIL capture_first: got n=%0d %h expected status 0 cap 1002", r_words.size(), packw());
        else n_pass++;
        latch_in[2] = 1'b1;
        repeat (5) tick();
        pulse_in[2] = ~pulse_in[2];
        repeat (6) tick();
        run_cmd(C_CAP, 2, 0, 0);
        n_checks++;
        if (r_words.size() != 3 || packw() !== {64'd1002, 32'd3} || r_done_cyc != 5 || r_end_data !== 32'd2)
            $display("FAIL capture_locked: got n=%0d %h done@%0d code %h expected status 3 cap 1002 done@5 code 2",
                     r_words.size(), packw(), r_done_cyc, r_end_data);
        else n_pass++;
    endtask

    task automatic test_sync();
        time_run = 1'b0;
        time_in  = 64'd1500;
        run_cmd(C_SYNC, 2, 32'h0, 32'h1);
        n_checks++;
        if (r_tout !== 64'h1_0000_0000 + 64'd502)
            $display("FAIL sync_value: got %h expected %h", r_tout, 64'h1_0000_0000 + 64'd502);
        else n_pass++;
        n_checks++;
        if (r_en_cnt != 1 || r_en_cyc != 4 || r_done_cyc != 4 || r_adv_cnt != 3 || r_extra_en !== 1'b0)
            $display("FAIL sync_timing: got en=%0d@%0d done@%0d adv=%0d en_after=%b expected 1@4 done@4 adv=3 0",
                     r_en_cnt, r_en_cyc, r_done_cyc, r_adv_cnt, r_extra_en);
        else n_pass++;
        run_cmd(C_CAP, 2, 0, 0);
        n_checks++;
        if (packw() !== {64'd1002, 32'd0})
            $display("FAIL sync_cleared: got %h expected status 0 cap 1002", packw());
        else n_pass++;
    endtask

    task automatic test_same_cycle();
        logic [63:0] t0;
        time_run = 1'b1;
        t0 = time_in;
        pulse_in[0] = ~pulse_in[0];
        latch_in[0] = 1'b1;
        repeat (6) tick();
        run_cmd(C_CAP, 0, 0, 0);
        n_checks++;
        if (packw() !== {t0 + 64'd2, 32'd1})
            $display("FAIL same_cycle: got %h expected %h", packw(), {t0 + 64'd2, 32'd1});
        else n_pass++;
        run_cmd(C_CAP, 7, 0, 0);
        n_checks++;
        if (r_words.size() != 3 || packw() !== {64'd0, 32'hFFFF_FFFF})
            $display("FAIL capture_bad_ch: got n=%0d %h expected status ffffffff cap 0", r_words.size(), packw());
        else n_pass++;
        run_cmd(C_SYNC, 9, 32'h5, 32'h6);
        n_checks++;
        if (r_en_cnt != 0 || r_done_cnt != 1 || r_done_cyc != 4)
            $display("FAIL sync_bad_ch: got en=%0d done=%0d@%0d expected 0 1@4", r_en_cnt, r_done_cnt, r_done_cyc);
        else n_pass++;
    endtask

    task automatic test_unknown();
        run_cmd(8'h55, 0, 0, 0);
        n_checks++;
        if (r_words.size() != 0 || r_done_cyc != 1 || r_end_data !== 32'd0 || r_adv_cnt != 0)
            $display("FAIL unknown_cmd: got n=%0d done@%0d code %h adv=%0d expected 0 1 0 0",
                     r_words.size(), r_done_cyc, r_end_data, r_adv_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        int ch, k;
        logic [63:0] off, exp_t;
        logic [31:0] st;
        logic [63:0] cp;
        for (int it = 0; it < 25; it++) begin
            time_run = 1'b1;
            repeat ($urandom_range(1, 8)) begin
                if ($urandom_range(0, 1) == 1) begin
                    k = $urandom_range(0, NCH - 1);
                    pulse_in[k] = ~pulse_in[k];
                end
                if ($urandom_range(0, 4) == 0) begin
                    k = $urandom_range(0, NCH - 1);
                    latch_in[k] = $urandom_range(0, 1) == 1;
                end
                tick();
            end
            repeat (4) tick();
            ch = $urandom_range(0, 5);
            if (ch < NCH && $urandom_range(0, 2) == 0) begin
                time_run = 1'b0;
                off   = {$urandom, $urandom};
                exp_t = time_in - m_cap[ch] + off + 64'd4;
                run_cmd(C_SYNC, 32'(ch), off[31:0], off[63:32]);
                n_checks++;
                if (r_en_cnt != 1 || r_tout !== exp_t)
                    $display("FAIL rand_sync%0d: got en=%0d %h expected 1 %h", it, r_en_cnt, r_tout, exp_t);
                else n_pass++;
            end else begin
                st = 32'hFFFF_FFFF;
                cp = '0;
                if (ch < NCH) begin
                    st = {30'd0, m_miss[ch], m_lock[ch]};
                    cp = m_cap[ch];
                end
                run_cmd(C_CAP, 32'(ch), 0, 0);
                n_checks++;
                if (r_words.size() != 3 || packw() !== {cp, st})
                    $display("FAIL rand_cap%0d ch%0d: got n=%0d %h expected %h", it, ch, r_words.size(), packw(), {cp, st});
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        time_run = 1'b0;
        time_in  = 64'h1234_5678_9ABC_DEF0;
        cmd = C_TIME; cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        n_checks++;
        if (param_write !== 1'b1) $display("FAIL midreset_stream: got pw %b expected 1", param_write);
        else n_pass++;
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({arg_advance, cmd_done, param_write, time_out_en, param_data, time_out} !== 100'd0)
            $display("FAIL midreset_outputs: got adv %b done %b pw %b en %b data %h tout %h expected all 0",
                     arg_advance, cmd_done, param_write, time_out_en, param_data, time_out);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (cmd_done !== 1'b0) $display("FAIL midreset_no_done: got %b expected 0", cmd_done);
        else n_pass++;
        run_cmd(C_TIME, 0, 0, 0);
        n_checks++;
        if (r_words.size() != 2 || packw() !== {32'd0, 64'h1234_5678_9ABC_DEF0} || r_done_cyc != 3)
            $display("FAIL midreset_retry: got n=%0d %h done@%0d expected 123456789abcdef0 done@3", r_words.size(), packw(), r_done_cyc);
        else n_pass++;
        run_cmd(C_CAP, 2, 0, 0);
        n_checks++;
        if (packw() !== 96'd0) $display("FAIL midreset_cap_cleared: got %h expected 0", packw());
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0; cmd = '0; cmd_ready = 1'b0; arg_data = '0;
        time_in = '0; pulse_in = '0; latch_in = '0; time_run = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            m_cap[c] = '0; m_lock[c] = 1'b0; m_miss[c] = 1'b0; ph[c] = '0; lh[c] = '0;
        end
        test_reset();
        test_version();
        test_get_time();
        test_capture();
        test_sync();
        test_same_cycle();
        test_unknown();
        test_random();
        test_reset_mid_stream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
